// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared synchronous-read data memory.
// Optional lock/burst support is enabled by defining MEMARB_LOCK_EN.
module mem_arbiter #(
    parameter int AW             = 12,
    parameter int DW             = 16,
    parameter int MEM_WORDS_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_rdwr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_rdwr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
`ifdef MEMARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          mem_cs,
    output logic          mem_we
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          sel_r, sel_s;
    logic          last_grant_r, last_grant_s;
    logic          tie_pick_s, tie_upd_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic          sel_rdwr_s;
    logic          oor_s;
    logic          resp_oor_r, resp_upd_r;
    logic [DW-1:0] rdata0_r, rdata1_r, rd_val_s;
    logic          m0_ack_s, m1_ack_s;

    function automatic logic addr_out_of_range(input logic [AW-1:0] addr);
        return |addr[AW-1:MEM_WORDS_LOG2];
    endfunction

    assign sel_addr_s  = sel_r ? m1_addr  : m0_addr;
    assign sel_wdata_s = sel_r ? m1_wdata : m0_wdata;
    assign sel_rdwr_s  = sel_r ? m1_rdwr  : m0_rdwr;
    assign oor_s       = addr_out_of_range(sel_addr_s);

`ifdef MEMARB_LOCK_EN
    logic       lock_vld_r, lock_owner_r;
    logic [2:0] lock_cnt_r;
    logic       grant_lock_s, lock_hold_s, lock_exp_s;

    assign grant_lock_s = sel_r ? m1_lock : m0_lock;
    assign lock_hold_s  = lock_vld_r && (lock_cnt_r < 3'd4);
    assign lock_exp_s   = lock_vld_r && (lock_cnt_r >= 3'd4);
    // A held lock keeps winning ties; once exhausted the other side is forced in.
    assign tie_pick_s   = lock_hold_s ? lock_owner_r : (lock_exp_s ? ~lock_owner_r : ~last_grant_r);
    assign tie_upd_s    = ~lock_hold_s;

    // Lock ownership and consecutive-grant count, evaluated when a transaction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld_r   <= 1'b0;
            lock_owner_r <= 1'b0;
            lock_cnt_r   <= 3'd0;
        end else if (state_r == ST_RESP) begin
            if (grant_lock_s) begin
                if (lock_vld_r && (lock_owner_r == sel_r)) begin
                    lock_cnt_r <= (lock_cnt_r != 3'd4) ? lock_cnt_r + 3'd1 : lock_cnt_r;
                end else begin
                    lock_vld_r   <= 1'b1;
                    lock_owner_r <= sel_r;
                    lock_cnt_r   <= 3'd1;
                end
            end else begin
                lock_vld_r <= 1'b0;
                lock_cnt_r <= 3'd0;
            end
        end else begin
            lock_vld_r <= lock_vld_r;
        end
    end
`else
    assign tie_pick_s = ~last_grant_r;
    assign tie_upd_s  = 1'b1;
`endif

    // State, grant index and round-robin history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sel_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Next-state and grant selection.
    always_comb begin
        state_s      = state_r;
        sel_s        = sel_r;
        last_grant_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    sel_s   = tie_pick_s;
                    state_s = ST_ACCESS;
                    if (tie_upd_s) begin
                        last_grant_s = tie_pick_s;
                    end else begin
                        last_grant_s = last_grant_r;
                    end
                end else if (m0_req) begin
                    sel_s   = 1'b0;
                    state_s = ST_ACCESS;
                end else if (m1_req) begin
                    sel_s   = 1'b1;
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Memory-side drive: only during ACCESS, with cs/we suppressed out of range.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        if (state_r == ST_ACCESS) begin
            mem_addr = sel_addr_s;
            mem_din  = sel_wdata_s;
            mem_cs   = ~oor_s;
            mem_we   = sel_rdwr_s & ~oor_s;
        end else begin
            mem_addr = '0;
        end
    end

    // Remember what the response must do: update rdata on reads and on any out-of-range access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_oor_r <= 1'b0;
            resp_upd_r <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            resp_oor_r <= oor_s;
            resp_upd_r <= ~sel_rdwr_s | oor_s;
        end else begin
            resp_oor_r <= resp_oor_r;
            resp_upd_r <= resp_upd_r;
        end
    end

    assign m0_ack_s = (state_r == ST_RESP) && !sel_r;
    assign m1_ack_s = (state_r == ST_RESP) &&  sel_r;
    assign rd_val_s = resp_oor_r ? '0 : mem_dout;

    // Read data arrives from the memory during RESP; capture it so it holds until the next ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            rdata0_r <= (m0_ack_s && resp_upd_r) ? rd_val_s : rdata0_r;
            rdata1_r <= (m1_ack_s && resp_upd_r) ? rd_val_s : rdata1_r;
        end
    end

    assign m0_ack   = m0_ack_s;
    assign m1_ack   = m1_ack_s;
    assign m0_err   = m0_ack_s & resp_oor_r;
    assign m1_err   = m1_ack_s & resp_oor_r;
    assign m0_rdata = (m0_ack_s && resp_upd_r) ? rd_val_s : rdata0_r;
    assign m1_rdata = (m1_ack_s && resp_upd_r) ? rd_val_s : rdata1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        m0_req = 1'b0, m0_rdwr = 1'b0, m1_req = 1'b0, m1_rdwr = 1'b0;
    logic [11:0] m0_addr = 12'h0, m1_addr = 12'h0;
    logic [15:0] m0_wdata = 16'h0, m1_wdata = 16'h0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
`ifdef MEMARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_cs, mem_we;
    logic [15:0] mem_model [8];
    int          errors = 0;
    int          checks = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_rdwr(m0_rdwr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_rdwr(m1_rdwr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
`ifdef MEMARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_cs(mem_cs), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // 8x16 synchronous-read memory; contents survive the arbiter reset.
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) mem_model[i] <= 16'h0000;
            mem_model[3] <= 16'hBEEF;
            mem_dout     <= 16'h0000;
        end else if (mem_cs) begin
            if (mem_we) mem_model[mem_addr[2:0]] <= mem_din;
            else        mem_dout <= mem_model[mem_addr[2:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst mem_cs", 32'(mem_cs), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_din", 32'(mem_din), 32'd0);
        chk("rst acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("rst errs", {30'd0, m1_err, m0_err}, 32'd0);
        chk("rst m0_rdata", 32'(m0_rdata), 32'd0);
        chk("rst m1_rdata", 32'(m1_rdata), 32'd0);
        rst = 1'b0;
    endtask

    // One isolated transaction on one port, checked cycle by cycle (ACCESS then RESP).
    task automatic run_txn(input int port, input logic wr, input logic [11:0] addr,
                           input logic [15:0] wd, input logic exp_cs,
                           input logic [15:0] exp_rd, input logic exp_err);
        if (port == 0) begin m0_req = 1'b1; m0_rdwr = wr; m0_addr = addr; m0_wdata = wd; end
        else           begin m1_req = 1'b1; m1_rdwr = wr; m1_addr = addr; m1_wdata = wd; end
        @(posedge clk); @(negedge clk);
        chk("access mem_cs", 32'(mem_cs), 32'(exp_cs));
        chk("access mem_we", 32'(mem_we), 32'(wr & exp_cs));
        chk("access no ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        if (exp_cs) chk("access mem_addr", 32'(mem_addr), 32'(addr));
        if (wr && exp_cs) chk("access mem_din", 32'(mem_din), 32'(wd));
        @(posedge clk); @(negedge clk);
        chk("resp ack", {30'd0, m1_ack, m0_ack}, (port == 0) ? 32'd1 : 32'd2);
        chk("resp err", 32'(port == 0 ? m0_err : m1_err), 32'(exp_err));
        chk("resp mem_cs", 32'(mem_cs), 32'd0);
        if (!wr) chk("resp rdata", 32'(port == 0 ? m0_rdata : m1_rdata), 32'(exp_rd));
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk("ack single pulse", {30'd0, m1_ack, m0_ack}, 32'd0);
    endtask

    // Wait (bounded) for the next ack; who = 0/1, or -1 on timeout.
    task automatic wait_ack(output int who);
        who = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (m0_ack || m1_ack) begin
                chk("one ack at a time", {30'd0, m1_ack, m0_ack} & 32'd3,
                    m0_ack ? 32'd1 : 32'd2);
                who = m0_ack ? 0 : 1;
                break;
            end
        end
    endtask

    initial begin
        int who;
        do_reset();
        preload = 1'b0;

        run_txn(0, 1'b0, 12'h003, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
        chk("m0 rdata held", 32'(m0_rdata), 32'h0000BEEF);
        run_txn(1, 1'b1, 12'h005, 16'h1234, 1'b1, 16'h0000, 1'b0);
        run_txn(1, 1'b0, 12'h005, 16'h0000, 1'b1, 16'h1234, 1'b0);
        run_txn(0, 1'b0, 12'h008, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Both held continuously from reset: strict alternation starting with m0.
        do_reset();
        m0_req = 1'b1; m0_rdwr = 1'b0; m0_addr = 12'h003;
        m1_req = 1'b1; m1_rdwr = 1'b0; m1_addr = 12'h005;
        for (int i = 0; i < 6; i++) begin
            wait_ack(who);
            chk($sformatf("rr order %0d", i), 32'(who), 32'(i % 2));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); @(negedge clk);

        // Reset in the ACCESS cycle of an m0 write aborts it without an ack.
        m0_req = 1'b1; m0_rdwr = 1'b1; m0_addr = 12'h002; m0_wdata = 16'h5555;
        @(posedge clk); @(negedge clk);
        chk("abort access cs", {30'd0, mem_cs, mem_we}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("abort cs drop", {30'd0, mem_cs, mem_we}, 32'd0);
        m0_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort no ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort no ack later", {30'd0, m1_ack, m0_ack}, 32'd0);

        // First tie after reset: m0 wins; its read also proves the aborted write never landed.
        m0_req = 1'b1; m0_rdwr = 1'b0; m0_addr = 12'h002;
        m1_req = 1'b1; m1_rdwr = 1'b0; m1_addr = 12'h005;
        wait_ack(who);
        chk("tie after reset", 32'(who), 32'd0);
        chk("aborted write absent", 32'(m0_rdata), 32'd0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        wait_ack(who);
        chk("m1 served next", 32'(who), 32'd1);
        chk("m1 rdata", 32'(m1_rdata), 32'h00001234);
        @(posedge clk); #1;
        m1_req = 1'b0;

`ifdef MEMARB_LOCK_EN
        // m0 locked with both requesting: four m0 grants, then m1, then m0 again.
        @(negedge clk);
        do_reset();
        m0_lock = 1'b1;
        m0_req = 1'b1; m0_rdwr = 1'b0; m0_addr = 12'h003;
        m1_req = 1'b1; m1_rdwr = 1'b0; m1_addr = 12'h005;
        for (int i = 0; i < 6; i++) begin
            wait_ack(who);
            chk($sformatf("lock order %0d", i), 32'(who), (i == 4) ? 32'd1 : 32'd0);
        end
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
        @(posedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
